// File: rtl/v30mz_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : v30mz_bus_pkg
//  Description : Shared bus command, bus status and BCU state types for the
//                V30MZ bus interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package v30mz_bus_pkg;

    // Command issued by the execution unit; held until eu_done
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } bus_command_t;

    // Encodings driven onto bus_status
    localparam logic [3:0] BUS_STATUS_IDLE  = 4'hf;
    localparam logic [3:0] BUS_STATUS_READ  = 4'b1001;
    localparam logic [3:0] BUS_STATUS_WRITE = 4'b1010;

    // BCU sequencer states
    typedef enum logic [1:0] {
        BCU_IDLE  = 2'd0,
        BCU_FETCH = 2'd1,
        BCU_EU_LO = 2'd2,
        BCU_EU_HI = 2'd3
    } bcu_state_t;

endpackage
`default_nettype wire

// File: rtl/bus_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bus_control_unit
//  Description : V30MZ bus control unit. Arbitrates EU accesses against
//                instruction prefetch, owns the prefetch pointer, splits
//                odd-address word accesses into two byte cycles and handles
//                prefetch flush/redirect on branches.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_control_unit
    import v30mz_bus_pkg::*;
#(
    parameter int QUEUE_DEPTH = 8,
    parameter int EU_PRIORITY = 1,
    parameter int ADDR_W      = 20
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [15:0]                    ps,
    input  logic                           flush,
    input  logic [15:0]                    flush_pfp,
    input  bus_command_t                   eu_cmd,
    input  logic                           eu_word,
    input  logic [ADDR_W-1:0]              eu_addr,
    input  logic [15:0]                    eu_wdata,
    output logic [15:0]                    eu_rdata,
    output logic                           eu_done,
    input  logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           queue_push,
    output logic                           queue_push_two,
    output logic [15:0]                    queue_data,
    output logic                           queue_clear,
    output logic [15:0]                    pfp,
    input  logic                           readyb,
    input  logic [15:0]                    data_in,
    output logic [15:0]                    data_out,
    output logic [ADDR_W-1:0]              address_out,
    output logic                           bus_ube_n,
    output logic [3:0]                     bus_status
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    // Wide enough for count + pending push + completing push + request size
    localparam int OCC_W = CNT_W + 1;

    bcu_state_t          state_q;
    logic [15:0]         pfp_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                ube_n_q;
    logic [3:0]          status_q;
    logic [15:0]         data_out_q;
    logic [15:0]         eu_rdata_q;
    logic                eu_done_q;
    logic                push_q;
    logic                push_two_q;
    logic [15:0]         qdata_q;
    logic                split_q;     // current EU access is an odd-address word
    logic                fetch_two_q; // current fetch is a word (even PFP)
    logic                discard_q;   // in-flight fetch was overtaken by a flush
    logic [7:0]          lo_byte_q;

    logic                fetch_done;
    logic                eu_finish;
    logic                boundary;
    logic                push_now;
    logic                eu_pending;
    logic [15:0]         pfp_d;
    logic [OCC_W-1:0]    occupied;
    logic [OCC_W-1:0]    need;
    logic                fetch_ok;
    logic                fetch_first;
    logic                issue_eu;
    logic                issue_fetch;
    logic [ADDR_W-1:0]   fetch_addr;

    // Issue arbitration and prefetch-pointer next value
    always_comb begin
        fetch_done  = (state_q == BCU_FETCH) && !readyb;
        eu_finish   = !readyb && ((state_q == BCU_EU_HI) ||
                                  ((state_q == BCU_EU_LO) && !split_q));
        boundary    = (state_q == BCU_IDLE) || fetch_done || eu_finish;
        push_now    = fetch_done && !discard_q && !flush;
        // eu_cmd is still held on the completing edge and the one after it
        eu_pending  = (eu_cmd != CMD_IDLE) && !eu_done_q && !eu_finish;

        pfp_d = pfp_q;
        if (flush)
            pfp_d = flush_pfp;
        else if (fetch_done && !discard_q)
            pfp_d = pfp_q + (fetch_two_q ? 16'd2 : 16'd1);

        // Bytes the queue will hold once pushes already committed have landed
        occupied = '0;
        if (!flush) begin
            occupied = OCC_W'(queue_count);
            if (push_q)
                occupied = occupied + (push_two_q ? OCC_W'(2) : OCC_W'(1));
            if (push_now)
                occupied = occupied + (fetch_two_q ? OCC_W'(2) : OCC_W'(1));
        end
        need        = pfp_d[0] ? OCC_W'(1) : OCC_W'(2);
        fetch_ok    = (occupied + need) <= OCC_W'(QUEUE_DEPTH);
        fetch_first = (EU_PRIORITY == 0) && (queue_count < CNT_W'(2));

        issue_eu    = boundary && eu_pending && !(fetch_first && fetch_ok);
        issue_fetch = boundary && fetch_ok && !issue_eu;
        fetch_addr  = {ps, 4'b0000} + {{(ADDR_W-16){1'b0}}, pfp_d};
    end

    // Bus cycle sequencer with registered bus, EU and queue outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BCU_IDLE;
            pfp_q       <= 16'h0000;
            addr_q      <= '1;
            ube_n_q     <= 1'b1;
            status_q    <= BUS_STATUS_IDLE;
            data_out_q  <= 16'h0000;
            eu_rdata_q  <= 16'h0000;
            eu_done_q   <= 1'b0;
            push_q      <= 1'b0;
            push_two_q  <= 1'b0;
            qdata_q     <= 16'h0000;
            split_q     <= 1'b0;
            fetch_two_q <= 1'b0;
            discard_q   <= 1'b0;
            lo_byte_q   <= 8'h00;
        end else begin
            eu_done_q <= 1'b0;
            push_q    <= 1'b0;
            pfp_q     <= pfp_d;

            if ((state_q == BCU_FETCH) && flush && !fetch_done)
                discard_q <= 1'b1;
            else if (fetch_done)
                discard_q <= 1'b0;

            if (push_now) begin
                push_q     <= 1'b1;
                push_two_q <= fetch_two_q;
                // Odd-PFP fetches arrive on the upper lane
                qdata_q    <= fetch_two_q ? data_in : {8'h00, data_in[15:8]};
            end

            // First half of a split word: low byte came in on the upper lane
            if ((state_q == BCU_EU_LO) && !readyb && split_q) begin
                lo_byte_q  <= data_in[15:8];
                state_q    <= BCU_EU_HI;
                addr_q     <= eu_addr + ADDR_W'(1);
                ube_n_q    <= 1'b1;
                data_out_q <= {8'h00, eu_wdata[15:8]};
            end

            if (eu_finish) begin
                eu_done_q <= 1'b1;
                if (eu_cmd == CMD_READ) begin
                    if (state_q == BCU_EU_HI)
                        eu_rdata_q <= {data_in[7:0], lo_byte_q};
                    else if (eu_word)
                        eu_rdata_q <= data_in;
                    else if (eu_addr[0])
                        eu_rdata_q <= {8'h00, data_in[15:8]};
                    else
                        eu_rdata_q <= {8'h00, data_in[7:0]};
                end
            end

            if (boundary) begin
                if (issue_eu) begin
                    state_q    <= BCU_EU_LO;
                    addr_q     <= eu_addr;
                    split_q    <= eu_word && eu_addr[0];
                    ube_n_q    <= !(eu_word || eu_addr[0]);
                    status_q   <= (eu_cmd == CMD_WRITE) ? BUS_STATUS_WRITE
                                                        : BUS_STATUS_READ;
                    if (eu_addr[0])
                        data_out_q <= {eu_wdata[7:0], 8'h00};
                    else if (eu_word)
                        data_out_q <= eu_wdata;
                    else
                        data_out_q <= {8'h00, eu_wdata[7:0]};
                end else if (issue_fetch) begin
                    state_q     <= BCU_FETCH;
                    addr_q      <= fetch_addr;
                    fetch_two_q <= !pfp_d[0];
                    discard_q   <= 1'b0;
                    ube_n_q     <= 1'b0;
                    status_q    <= BUS_STATUS_READ;
                end else begin
                    state_q  <= BCU_IDLE;
                    ube_n_q  <= 1'b1;
                    status_q <= BUS_STATUS_IDLE;
                end
            end
        end
    end

    assign queue_clear    = flush;
    assign pfp            = pfp_q;
    assign address_out    = addr_q;
    assign bus_ube_n      = ube_n_q;
    assign bus_status     = status_q;
    assign data_out       = data_out_q;
    assign eu_rdata       = eu_rdata_q;
    assign eu_done        = eu_done_q;
    assign queue_push     = push_q;
    assign queue_push_two = push_two_q;
    assign queue_data     = qdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_control_unit
//  Description : Directed self-checking bench for bus_control_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_control_unit;
    import v30mz_bus_pkg::*;

    logic         clk;
    logic         reset;
    logic [15:0]  ps;
    logic         flush;
    logic [15:0]  flush_pfp;
    bus_command_t eu_cmd;
    logic         eu_word;
    logic [19:0]  eu_addr;
    logic [15:0]  eu_wdata;
    logic [15:0]  eu_rdata;
    logic         eu_done;
    logic [3:0]   queue_count;
    logic         queue_push;
    logic         queue_push_two;
    logic [15:0]  queue_data;
    logic         queue_clear;
    logic [15:0]  pfp;
    logic         readyb;
    logic [15:0]  data_in;
    logic [15:0]  data_out;
    logic [19:0]  address_out;
    logic         bus_ube_n;
    logic [3:0]   bus_status;

    int checks = 0;
    int errors = 0;

    bus_control_unit #(.QUEUE_DEPTH(8), .EU_PRIORITY(1), .ADDR_W(20)) dut (
        .clk            (clk),
        .reset          (reset),
        .ps             (ps),
        .flush          (flush),
        .flush_pfp      (flush_pfp),
        .eu_cmd         (eu_cmd),
        .eu_word        (eu_word),
        .eu_addr        (eu_addr),
        .eu_wdata       (eu_wdata),
        .eu_rdata       (eu_rdata),
        .eu_done        (eu_done),
        .queue_count    (queue_count),
        .queue_push     (queue_push),
        .queue_push_two (queue_push_two),
        .queue_data     (queue_data),
        .queue_clear    (queue_clear),
        .pfp            (pfp),
        .readyb         (readyb),
        .data_in        (data_in),
        .data_out       (data_out),
        .address_out    (address_out),
        .bus_ube_n      (bus_ube_n),
        .bus_status     (bus_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ps = 16'hffff; flush = 1'b0; flush_pfp = 16'h0000;
        eu_cmd = CMD_IDLE; eu_word = 1'b0; eu_addr = 20'h0; eu_wdata = 16'h0;
        queue_count = 4'd0; readyb = 1'b0; data_in = 16'h0000;

        // Reset state
        #12;
        check("rst_status", 32'(bus_status), 32'hf);
        check("rst_addr", 32'(address_out), 32'hfffff);
        check("rst_ube", 32'(bus_ube_n), 32'h1);
        check("rst_pfp", 32'(pfp), 32'h0);
        check("rst_done", 32'(eu_done), 32'h0);
        check("rst_push", 32'(queue_push), 32'h0);
        check("rst_dout", 32'(data_out), 32'h0);
        check("rst_rdata", 32'(eu_rdata), 32'h0);
        #1 reset = 1'b0;

        // First fetch: word at {ps,0}
        tick();
        check("f1_addr", 32'(address_out), 32'hffff0);
        check("f1_status", 32'(bus_status), 32'h9);
        check("f1_ube", 32'(bus_ube_n), 32'h0);
        data_in = 16'h2211;
        tick();
        check("f1_push", 32'(queue_push), 32'h1);
        check("f1_two", 32'(queue_push_two), 32'h1);
        check("f1_data", 32'(queue_data), 32'h2211);
        check("f1_pfp", 32'(pfp), 32'h2);
        check("f2_addr", 32'(address_out), 32'hffff2);

        // Flush during fetch wait state, redirect to odd PFP
        readyb = 1'b1; flush = 1'b1; flush_pfp = 16'h0003;
        #1 check("clr_hi", 32'(queue_clear), 32'h1);
        tick();
        check("fl_pfp", 32'(pfp), 32'h3);
        check("fl_push0", 32'(queue_push), 32'h0);
        flush = 1'b0; readyb = 1'b0; data_in = 16'haa55;
        #1 check("clr_lo", 32'(queue_clear), 32'h0);
        tick();
        check("fl_nopush", 32'(queue_push), 32'h0);
        check("odd_addr", 32'(address_out), 32'hffff3);
        check("odd_ube", 32'(bus_ube_n), 32'h0);
        data_in = 16'h7c00;
        tick();
        check("odd_push", 32'(queue_push), 32'h1);
        check("odd_two", 32'(queue_push_two), 32'h0);
        check("odd_data", 32'(queue_data), 32'h007c);
        check("odd_pfp", 32'(pfp), 32'h4);
        check("f4_addr", 32'(address_out), 32'hffff4);

        // Queue nearly full: fetch stops
        queue_count = 4'd6; data_in = 16'h1234;
        tick();
        check("f4_data", 32'(queue_data), 32'h1234);
        check("f4_pfp", 32'(pfp), 32'h6);
        check("full_st0", 32'(bus_status), 32'hf);
        queue_count = 4'd7;
        tick();
        check("full_st1", 32'(bus_status), 32'hf);
        tick();
        check("full_st2", 32'(bus_status), 32'hf);

        // EU word read at odd address: two byte cycles
        eu_cmd = CMD_READ; eu_word = 1'b1; eu_addr = 20'h00101; data_in = 16'h3412;
        tick();
        check("rd_addr_lo", 32'(address_out), 32'h00101);
        check("rd_status", 32'(bus_status), 32'h9);
        check("rd_ube_lo", 32'(bus_ube_n), 32'h0);
        tick();
        check("rd_addr_hi", 32'(address_out), 32'h00102);
        check("rd_done_mid", 32'(eu_done), 32'h0);
        data_in = 16'h7856;
        tick();
        check("rd_done", 32'(eu_done), 32'h1);
        check("rd_data", 32'(eu_rdata), 32'h5634);
        check("rd_idle", 32'(bus_status), 32'hf);
        eu_cmd = CMD_IDLE;
        tick();
        check("rd_done_end", 32'(eu_done), 32'h0);

        // EU word write with three wait states
        eu_cmd = CMD_WRITE; eu_word = 1'b1; eu_addr = 20'h00200; eu_wdata = 16'hbeef;
        readyb = 1'b1;
        tick();
        check("wr_status0", 32'(bus_status), 32'ha);
        check("wr_dout", 32'(data_out), 32'hbeef);
        check("wr_addr", 32'(address_out), 32'h00200);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wr_status_w", 32'(bus_status), 32'ha);
            check("wr_done_w", 32'(eu_done), 32'h0);
        end
        readyb = 1'b0;
        tick();
        check("wr_done", 32'(eu_done), 32'h1);
        check("wr_idle", 32'(bus_status), 32'hf);

        // Prefetch resumes, then reset aborts the cycle
        eu_cmd = CMD_IDLE; queue_count = 4'd0; readyb = 1'b1;
        tick();
        check("f6_addr", 32'(address_out), 32'hffff6);
        check("f6_status", 32'(bus_status), 32'h9);
        #2 reset = 1'b1;
        #1;
        check("ab_status", 32'(bus_status), 32'hf);
        check("ab_addr", 32'(address_out), 32'hfffff);
        check("ab_pfp", 32'(pfp), 32'h0);
        check("ab_push", 32'(queue_push), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
